// File: rtl/blit_queue.sv
// Sprite blitter command scheduler: CPU stages six-word draw commands into a FIFO,
// which are replayed one at a time into the blitter register port with start/poll handshaking.
module blit_queue #(
  parameter int DEPTH    = 8,
  parameter int POLL_GAP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  avalon_slave_address,
  input  logic        avalon_slave_read,
  output logic [31:0] avalon_slave_readdata,
  input  logic        avalon_slave_write,
  input  logic [31:0] avalon_slave_writedata,
  output logic [2:0]  blit_address,
  output logic        blit_read,
  input  logic [31:0] blit_readdata,
  output logic        blit_write,
  output logic [31:0] blit_writedata,
  output logic        irq
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int GW = $clog2(POLL_GAP + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    KICK      = 3'd2,
    POLL_RD   = 3'd3,
    POLL_WAIT = 3'd4,
    GAP       = 3'd5,
    DONE_CMD  = 3'd6
  } state_t;

  state_t         state;
  logic [2:0]     load_idx;
  logic [GW-1:0]  gap_cnt;
  logic [191:0]   mem [DEPTH];
  logic [31:0]    staged [1:6];
  logic [AW-1:0]  head, tail, tail_base;
  logic [CW-1:0]  count, cnt_base, cnt_pop, count_next;
  logic           overflow;
  logic [31:0]    completed;
  logic           ctrl_wr, push, flush, irq_clr, ovf_clr, pop, push_ok, push_drop;
  logic [191:0]   head_entry, staged_entry;
  logic [31:0]    status;
  logic           unused_rdata;

  function automatic logic [31:0] entry_word(input logic [191:0] e, input logic [2:0] k);
    case (k)
      3'd1:    entry_word = e[31:0];
      3'd2:    entry_word = e[63:32];
      3'd3:    entry_word = e[95:64];
      3'd4:    entry_word = e[127:96];
      3'd5:    entry_word = e[159:128];
      3'd6:    entry_word = e[191:160];
      default: entry_word = 32'h0;
    endcase
  endfunction

  assign ctrl_wr      = avalon_slave_write && (avalon_slave_address == 3'd0);
  assign push         = ctrl_wr && avalon_slave_writedata[0];
  assign flush        = ctrl_wr && avalon_slave_writedata[1];
  assign irq_clr      = ctrl_wr && avalon_slave_writedata[2];
  assign ovf_clr      = ctrl_wr && avalon_slave_writedata[3];
  assign pop          = (state == DONE_CMD);
  assign head_entry   = mem[head];
  assign staged_entry = {staged[6], staged[5], staged[4], staged[3], staged[2], staged[1]};
  assign status       = {16'h0, 8'(count), 4'h0, overflow, count == CW'(DEPTH),
                         count == CW'(0), state != IDLE};
  assign unused_rdata = ^blit_readdata[31:1];

  // Next occupancy: flush keeps only the in-flight head, then the pop, then the push.
  always_comb begin
    cnt_base  = count;
    tail_base = tail;
    if (flush) begin
      if (state != IDLE) begin
        cnt_base  = CW'(1);
        tail_base = head + AW'(1);
      end else begin
        cnt_base  = CW'(0);
        tail_base = head;
      end
    end else begin
      cnt_base  = count;
      tail_base = tail;
    end
    cnt_pop    = pop ? (cnt_base - CW'(1)) : cnt_base;
    push_ok    = push && (cnt_pop != CW'(DEPTH));
    push_drop  = push && !push_ok;
    count_next = push_ok ? (cnt_pop + CW'(1)) : cnt_pop;
  end

  // Queue bookkeeping, staged words, sticky flags and completion counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      completed <= 32'h0;
      irq       <= 1'b0;
      for (int i = 1; i <= 6; i++) staged[i] <= 32'h0;
    end else begin
      count <= count_next;
      tail  <= push_ok ? (tail_base + AW'(1)) : tail_base;
      if (pop) head <= head + AW'(1);
      if (push_drop) overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      if (avalon_slave_write && avalon_slave_address == 3'd7) completed <= 32'h0;
      else if (pop) completed <= completed + 32'd1;
      if (pop && count_next == CW'(0)) irq <= 1'b1;
      else if (irq_clr) irq <= 1'b0;
      if (avalon_slave_write && avalon_slave_address != 3'd0 && avalon_slave_address != 3'd7)
        staged[avalon_slave_address] <= avalon_slave_writedata;
    end
  end

  // Entry storage; contents are meaningless outside the head..tail window.
  always_ff @(posedge clk) begin
    if (push_ok) mem[tail_base] <= staged_entry;
  end

  // Registered CPU read port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avalon_slave_readdata <= 32'h0;
    end else if (avalon_slave_read) begin
      case (avalon_slave_address)
        3'd0:    avalon_slave_readdata <= status;
        3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6:
                 avalon_slave_readdata <= staged[avalon_slave_address];
        3'd7:    avalon_slave_readdata <= completed;
        default: avalon_slave_readdata <= 32'h0;
      endcase
    end else begin
      avalon_slave_readdata <= 32'h0;
    end
  end

  // Blitter sequencer: outputs are set one edge ahead of the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      load_idx       <= 3'd0;
      gap_cnt        <= '0;
      blit_write     <= 1'b0;
      blit_read      <= 1'b0;
      blit_address   <= 3'd0;
      blit_writedata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          blit_read <= 1'b0;
          if (count != CW'(0) && !flush) begin
            state          <= LOAD;
            load_idx       <= 3'd1;
            blit_write     <= 1'b1;
            blit_address   <= 3'd1;
            blit_writedata <= entry_word(head_entry, 3'd1);
          end else begin
            blit_write     <= 1'b0;
            blit_address   <= 3'd0;
            blit_writedata <= 32'h0;
          end
        end
        LOAD: begin
          blit_write <= 1'b1;
          if (load_idx == 3'd6) begin
            state          <= KICK;
            blit_address   <= 3'd0;
            blit_writedata <= 32'h1;
          end else begin
            load_idx       <= load_idx + 3'd1;
            blit_address   <= load_idx + 3'd1;
            blit_writedata <= entry_word(head_entry, load_idx + 3'd1);
          end
        end
        KICK: begin
          state          <= POLL_RD;
          blit_write     <= 1'b0;
          blit_read      <= 1'b1;
          blit_address   <= 3'd0;
          blit_writedata <= 32'h0;
        end
        POLL_RD: begin
          state     <= POLL_WAIT;
          blit_read <= 1'b0;
        end
        POLL_WAIT: begin
          gap_cnt <= '0;
          if (blit_readdata[0] == 1'b0) state <= DONE_CMD;
          else state <= GAP;
        end
        GAP: begin
          if (gap_cnt == GW'(POLL_GAP - 1)) begin
            state     <= POLL_RD;
            blit_read <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        DONE_CMD: begin
          state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          blit_write <= 1'b0;
          blit_read  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_blit_queue.sv
// Randomized bench for blit_queue: a behavioural blitter plus a command-level queue model.
module tb_blit_queue;
  localparam int DEPTH    = 8;
  localparam int POLL_GAP = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  avalon_slave_address;
  logic        avalon_slave_read;
  logic [31:0] avalon_slave_readdata;
  logic        avalon_slave_write;
  logic [31:0] avalon_slave_writedata;
  logic [2:0]  blit_address;
  logic        blit_read;
  logic [31:0] blit_readdata;
  logic        blit_write;
  logic [31:0] blit_writedata;
  logic        irq;

  blit_queue #(.DEPTH(DEPTH), .POLL_GAP(POLL_GAP)) dut (
    .clk(clk), .reset(reset),
    .avalon_slave_address(avalon_slave_address), .avalon_slave_read(avalon_slave_read),
    .avalon_slave_readdata(avalon_slave_readdata), .avalon_slave_write(avalon_slave_write),
    .avalon_slave_writedata(avalon_slave_writedata),
    .blit_address(blit_address), .blit_read(blit_read), .blit_readdata(blit_readdata),
    .blit_write(blit_write), .blit_writedata(blit_writedata), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Command-level model: every accepted command in order, with a flushed mark.
  logic [191:0] acc[$];
  bit           cancel[$];
  logic [31:0]  stg [1:6];
  bit           exp_ovf;
  int           done_base, done_at_clear;

  // Bench-controlled blitter behaviour.
  bit stall, rand_busy, irq_watch;
  int busy_polls;

  // Blitter model state.
  bit           start, inflight, done_seen;
  int           polls_left, load_pos, issued, model_done, cyc, kick_cyc, last_rd;
  logic [31:0]  got_words [1:6];
  logic [191:0] cur;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int next_live(input int from);
    int j = from;
    while (j < acc.size() && cancel[j]) j++;
    return j;
  endfunction

  function automatic int pending();
    int n = 0;
    for (int i = issued; i < acc.size(); i++) if (!cancel[i]) n++;
    return n;
  endfunction

  function automatic logic [31:0] exp_status(input bit busy);
    int c = pending() + int'(inflight);
    return {16'h0, 8'(c), 4'h0, exp_ovf, c == DEPTH, c == 0, busy};
  endfunction

  // Blitter register port model and protocol monitor.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      start <= 1'b0; inflight <= 1'b0; done_seen <= 1'b0;
      polls_left <= 0; load_pos <= 0; issued <= 0; model_done <= 0; last_rd <= -1;
      blit_readdata <= 32'h0;
    end else begin
      blit_readdata <= 32'h0;
      if (blit_write && blit_address != 3'd0) begin
        check("load_order", 32'(blit_address), 32'(load_pos + 1));
        load_pos <= int'(blit_address);
        got_words[blit_address] <= blit_writedata;
        if (blit_address == 3'd1) begin
          if (next_live(issued) >= acc.size()) check("unexpected_cmd", 32'd1, 32'd0);
          else cur <= acc[next_live(issued)];
          issued   <= next_live(issued) + 1;
          inflight <= 1'b1;
        end
      end
      if (blit_write && blit_address == 3'd0) begin
        check("kick_while_busy", 32'(start), 32'd0);
        check("kick_data", blit_writedata, 32'h1);
        check("load_count", 32'(load_pos), 32'd6);
        for (int k = 1; k <= 6; k++) check("cmd_word", got_words[k], cur[32*(k-1) +: 32]);
        if (irq_watch) check("irq_early", 32'(irq), 32'd0);
        start      <= 1'b1;
        polls_left <= rand_busy ? int'($urandom_range(0, 3)) : busy_polls;
        done_seen  <= 1'b0;
        kick_cyc   <= cyc;
        last_rd    <= -1;
        load_pos   <= 0;
      end
      if (blit_read) begin
        check("poll_addr", 32'(blit_address), 32'd0);
        if (done_seen) check("read_after_done", 32'd1, 32'd0);
        if (last_rd < 0) check("first_poll", 32'(cyc - kick_cyc), 32'd1);
        else check("poll_spacing", 32'(cyc - last_rd), 32'(POLL_GAP + 2));
        last_rd <= cyc;
        if (start && (stall || polls_left != 0)) begin
          blit_readdata <= 32'h1;
          if (!stall) polls_left <= polls_left - 1;
        end else if (start) begin
          start      <= 1'b0;
          done_seen  <= 1'b1;
          inflight   <= 1'b0;
          model_done <= model_done + 1;
        end
      end
    end
  end

  task automatic cpu_write(input logic [2:0] a, input logic [31:0] d);
    avalon_slave_address   = a;
    avalon_slave_writedata = d;
    avalon_slave_write     = 1'b1;
    @(negedge clk);
    avalon_slave_write     = 1'b0;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [31:0] d);
    avalon_slave_address = a;
    avalon_slave_read    = 1'b1;
    @(negedge clk);
    avalon_slave_read    = 1'b0;
    d = avalon_slave_readdata;
  endtask

  task automatic stage(input int a, input logic [31:0] d);
    cpu_write(3'(a), d);
    stg[a] = d;
  endtask

  task automatic stage_random();
    for (int k = 1; k <= 6; k++) stage(k, $urandom());
  endtask

  task automatic ctrl(input logic [31:0] d);
    if (d[1]) for (int i = issued; i < acc.size(); i++) cancel[i] = 1'b1;
    if (d[3]) exp_ovf = 1'b0;
    if (d[2]) done_at_clear = model_done;
    if (d[0]) begin
      if (pending() + int'(inflight) < DEPTH) begin
        acc.push_back({stg[6], stg[5], stg[4], stg[3], stg[2], stg[1]});
        cancel.push_back(1'b0);
      end else begin
        exp_ovf = 1'b1;
      end
    end
    cpu_write(3'd0, d);
  endtask

  task automatic wait_idle();
    logic [31:0] s;
    int i;
    s = 32'h0;
    for (i = 0; i < 3000; i++) begin
      cpu_read(3'd0, s);
      if (s[0] == 1'b0 && s[1] == 1'b1) break;
    end
    if (i == 3000) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    logic [31:0] r;
    cpu_read(3'd0, r);
    check({tag, "_status"}, r, exp_status(1'b0));
    cpu_read(3'd7, r);
    check({tag, "_completed"}, r, 32'(model_done - done_base));
    check({tag, "_irq"}, 32'(irq), 32'(model_done != done_at_clear));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int k, mode;
    reset = 1'b1;
    avalon_slave_address = 3'd0; avalon_slave_read = 1'b0;
    avalon_slave_write = 1'b0; avalon_slave_writedata = 32'h0;
    stall = 1'b0; rand_busy = 1'b0; irq_watch = 1'b0; busy_polls = 0;
    exp_ovf = 1'b0; done_base = 0; done_at_clear = 0;
    for (int i = 1; i <= 6; i++) stg[i] = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_blit", {28'h0, blit_write, blit_read, blit_address == 3'd0}, 32'h1);
    cpu_read(3'd0, r); check("rst_status", r, 32'h2);
    cpu_read(3'd7, r); check("rst_completed", r, 32'h0);
    cpu_read(3'd1, r); check("rst_staged", r, 32'h0);

    // Single command with the reference parameter set
    stage(1, 32'h1000); stage(2, 32'h2000); stage(3, 32'h0010_0010);
    stage(4, 32'h0020_0020); stage(5, 32'h0); stage(6, 32'h0010_0010);
    cpu_read(3'd2, r); check("staged_rd", r, 32'h2000);
    busy_polls = 8;
    ctrl(32'h1);
    check("t1_no_early_wr", 32'(blit_write), 32'd0);
    @(negedge clk);
    check("t1_first_wr", {28'h0, blit_write, blit_address}, 32'h9);
    check("t1_first_data", blit_writedata, 32'h1000);
    wait_idle();
    check_quiet("t1");
    cpu_read(3'd1, r); check("staged_persist", r, 32'h1000);

    // Three back-to-back commands; irq only after the last
    ctrl(32'h4);
    check("t2_irq_clr", 32'(irq), 32'd0);
    stall = 1'b1; irq_watch = 1'b1; busy_polls = 1;
    for (int i = 0; i < 3; i++) begin stage_random(); ctrl(32'h1); end
    stall = 1'b0;
    wait_idle();
    irq_watch = 1'b0;
    check("t2_done", 32'(model_done - done_at_clear), 32'd3);
    check_quiet("t2");

    // Overflow with a stalled blitter
    ctrl(32'h4);
    stall = 1'b1; busy_polls = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin stage_random(); ctrl(32'h1); end
    cpu_read(3'd0, r); check("t3_full", r, exp_status(1'b1));
    check("t3_ovf_model", 32'(exp_ovf), 32'd1);
    ctrl(32'h8);
    cpu_read(3'd0, r); check("t3_ovf_clr", r, exp_status(1'b1));
    stall = 1'b0;
    wait_idle();
    check_quiet("t3");

    // Flush with four queued, first in flight
    ctrl(32'h4);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin stage_random(); ctrl(32'h1); end
    cpu_read(3'd0, r); check("t4_four", r, exp_status(1'b1));
    ctrl(32'h2);
    cpu_read(3'd0, r); check("t4_flushed", r, exp_status(1'b1));
    stall = 1'b0;
    wait_idle();
    check("t4_done", 32'(model_done - done_at_clear), 32'd1);
    check_quiet("t4");

    // Busy for three polls, done at the fourth
    busy_polls = 3;
    stage_random(); ctrl(32'h1);
    wait_idle();
    check_quiet("t5");

    // Reset in the middle of LOAD
    busy_polls = 2;
    stage_random(); ctrl(32'h1);
    for (int i = 0; i < 20 && !(blit_write && blit_address == 3'd3); i++) @(negedge clk);
    check("t6_at_a3", {28'h0, blit_write, blit_address}, 32'hB);
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check("t6_rst_outs", {29'h0, blit_write, blit_read, irq}, 32'h0);
    acc.delete(); cancel.delete(); exp_ovf = 1'b0;
    for (int i = 1; i <= 6; i++) stg[i] = 32'h0;
    done_base = 0; done_at_clear = 0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_quiet("t6_after");
    stage_random(); ctrl(32'h1);
    @(negedge clk);
    check("t6_restart", {28'h0, blit_write, blit_address}, 32'h9);
    wait_idle();
    check_quiet("t6_done");

    // Randomized rounds: bursts, overflow, flush and flush+push
    rand_busy = 1'b1;
    for (int round = 0; round < 8; round++) begin
      ctrl(32'hC);
      stall = 1'b1;
      k = $urandom_range(1, DEPTH + 2);
      for (int i = 0; i < k; i++) begin stage_random(); ctrl(32'h1); end
      cpu_read(3'd0, r); check("rnd_burst", r, exp_status(inflight));
      repeat (2) @(negedge clk);
      mode = $urandom_range(0, 2);
      if (mode == 1) ctrl(32'h2);
      if (mode == 2) begin stage_random(); ctrl(32'h3); end
      cpu_read(3'd0, r); check("rnd_post", r, exp_status(1'b1));
      stall = 1'b0;
      wait_idle();
      check_quiet("rnd");
    end

    // Any write to the completed register clears it
    cpu_write(3'd7, $urandom());
    done_base = model_done;
    cpu_read(3'd7, r); check("completed_clr", r, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
